// File: rtl/dich_led.sv
// dich_led -- LED pattern generator for an 8-LED bank.
//
// Produces four animated patterns selected by a 2-bit mode input:
//   0 rotate-left, 1 rotate-right, 2 fill/empty bar, 3 ping-pong.
// The pattern advances once every STEP_DIV clocks. A change of mode reloads
// the start pattern for the new mode on the edge it is sampled and restarts
// the step interval.
//
// Parameters:
//   STEP_DIV  clock cycles per pattern step (>= 1), default 1.
// Ports:
//   clk    input   system clock, rising-edge active
//   reset  input   synchronous, active-high reset
//   mode   input   [1:0] pattern select
//   q      output  [7:0] registered LED drive, bit 0 is the rightmost LED
//
// Build option:
//   DICHLED_ACTIVE_LOW_EN  when defined, q drives ~pattern for active-low LED
//                          boards. Internal sequencing is unchanged.
module dich_led #(
  parameter int STEP_DIV = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] mode,
  output logic [7:0] q
);

  // A one-bit counter is kept even when STEP_DIV is 1 so the logic stays uniform.
  localparam int CW = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(STEP_DIV - 1);

  logic [7:0]    pat_r;
  logic [1:0]    mode_r;
  logic          ph_r;
  logic [CW-1:0] cnt_r;

  logic [7:0]    pat_nx_s;
  logic          ph_nx_s;
  logic [CW-1:0] cnt_nx_s;
  logic          tick_s;

  // Pattern loaded when a mode is entered.
  function automatic logic [7:0] start_pat(input logic [1:0] m);
    logic [7:0] p;
    case (m)
      2'd0:    p = 8'h01;
      2'd1:    p = 8'h80;
      2'd2:    p = 8'h00;
      2'd3:    p = 8'h01;
      default: p = 8'h01;
    endcase
    return p;
  endfunction

  // Map the internal pattern onto the LED pin polarity.
  function automatic logic [7:0] led_drive(input logic [7:0] p);
`ifdef DICHLED_ACTIVE_LOW_EN
    return ~p;
`else
    return p;
`endif
  endfunction

  // Next-state logic: mode reload has priority over a step, otherwise hold.
  always_comb begin
    pat_nx_s = pat_r;
    ph_nx_s  = ph_r;
    cnt_nx_s = cnt_r;
    tick_s   = (cnt_r == CNT_MAX);
    if (mode != mode_r) begin
      pat_nx_s = start_pat(mode);
      ph_nx_s  = 1'b0;
      cnt_nx_s = {CW{1'b0}};
    end else if (tick_s) begin
      cnt_nx_s = {CW{1'b0}};
      case (mode_r)
        2'd0: begin
          pat_nx_s = {pat_r[6:0], pat_r[7]};
        end
        2'd1: begin
          pat_nx_s = {pat_r[0], pat_r[7:1]};
        end
        2'd2: begin
          // Fill with ones until full, then drain with zeros until empty.
          if (ph_r == 1'b0) begin
            if (pat_r == 8'hFF) begin
              pat_nx_s = {pat_r[6:0], 1'b0};
              ph_nx_s  = 1'b1;
            end else begin
              pat_nx_s = {pat_r[6:0], 1'b1};
            end
          end else begin
            if (pat_r == 8'h00) begin
              pat_nx_s = {pat_r[6:0], 1'b1};
              ph_nx_s  = 1'b0;
            end else begin
              pat_nx_s = {pat_r[6:0], 1'b0};
            end
          end
        end
        2'd3: begin
          // Direction flips on the step that reaches an end, so each end is shown once.
          if (ph_r == 1'b0) begin
            pat_nx_s = {pat_r[6:0], 1'b0};
            if (pat_nx_s == 8'h80) begin
              ph_nx_s = 1'b1;
            end else begin
              ph_nx_s = 1'b0;
            end
          end else begin
            pat_nx_s = {1'b0, pat_r[7:1]};
            if (pat_nx_s == 8'h01) begin
              ph_nx_s = 1'b0;
            end else begin
              ph_nx_s = 1'b1;
            end
          end
        end
        default: begin
          pat_nx_s = pat_r;
        end
      endcase
    end else begin
      cnt_nx_s = cnt_r + CW'(1);
    end
  end

  // State and output registers; reset has priority over everything.
  always_ff @(posedge clk) begin
    if (reset) begin
      pat_r  <= 8'h01;
      mode_r <= 2'd0;
      ph_r   <= 1'b0;
      cnt_r  <= {CW{1'b0}};
      q      <= led_drive(8'h01);
    end else begin
      pat_r  <= pat_nx_s;
      mode_r <= mode;
      ph_r   <= ph_nx_s;
      cnt_r  <= cnt_nx_s;
      q      <= led_drive(pat_nx_s);
    end
  end

endmodule

// File: tb/tb_dich_led.sv
// Directed testbench for dich_led: one instance with STEP_DIV=1 and one with
// STEP_DIV=4, sharing a clock. Inputs change 1 time unit after a rising edge
// and outputs are sampled at that same point, well away from the next edge.
module tb_dich_led;

  logic       clk;
  logic       reset_a;
  logic [1:0] mode_a;
  logic [7:0] q_a;
  logic       reset_b;
  logic [1:0] mode_b;
  logic [7:0] q_b;

  int errors;
  int checks;

  dich_led #(.STEP_DIV(1)) dut_a (
    .clk   (clk),
    .reset (reset_a),
    .mode  (mode_a),
    .q     (q_a)
  );

  dich_led #(.STEP_DIV(4)) dut_b (
    .clk   (clk),
    .reset (reset_b),
    .mode  (mode_b),
    .q     (q_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [7:0] exp_fill [20] = '{
    8'h00, 8'h01, 8'h03, 8'h07, 8'h0F, 8'h1F, 8'h3F, 8'h7F, 8'hFF, 8'hFE,
    8'hFC, 8'hF8, 8'hF0, 8'hE0, 8'hC0, 8'h80, 8'h00, 8'h01, 8'h03, 8'h07
  };
  logic [7:0] exp_pp [16] = '{
    8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80,
    8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01, 8'h02
  };
  logic [7:0] exp_b [8] = '{
    8'h01, 8'h01, 8'h01, 8'h02, 8'h02, 8'h02, 8'h02, 8'h04
  };

  // Expected pin value for a given internal pattern.
  function automatic logic [7:0] led(input logic [7:0] p);
`ifdef DICHLED_ACTIVE_LOW_EN
    return ~p;
`else
    return p;
`endif
  endfunction

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks = checks + 1;
    if (got !== exp) begin
      errors = errors + 1;
      $display("FAIL %s: got %02h expected %02h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    errors  = 0;
    checks  = 0;
    reset_a = 1'b1;
    mode_a  = 2'd0;
    reset_b = 1'b1;
    mode_b  = 2'd0;

    // Reset held two cycles.
    step(); check("reset1", q_a, led(8'h01));
    step(); check("reset2", q_a, led(8'h01));
    reset_a = 1'b0;

    // Rotate left after release: 02..80, 01.
    for (int i = 1; i <= 8; i++) begin
      step(); check("rotl", q_a, led(8'h01 << (i % 8)));
    end
    step(); check("rotl_a", q_a, led(8'h02));
    step(); check("rotl_b", q_a, led(8'h04));

    // Switch to rotate right mid-sequence.
    mode_a = 2'd1;
    step(); check("rotr_load", q_a, led(8'h80));
    for (int i = 1; i <= 8; i++) begin
      step(); check("rotr", q_a, led(8'h80 >> (i % 8)));
    end

    // Fill/empty bar.
    mode_a = 2'd2;
    for (int i = 0; i < 20; i++) begin
      step(); check("bar", q_a, led(exp_fill[i]));
    end

    // Ping-pong.
    mode_a = 2'd3;
    for (int i = 0; i < 16; i++) begin
      step(); check("pingpong", q_a, led(exp_pp[i]));
    end
    // Continue from 02 (moving left) to 20 while moving right.
    for (int i = 0; i < 8; i++) begin
      step();
    end
    check("pp_at20", q_a, led(8'h20));

    // Reset while moving right in mode 3.
    reset_a = 1'b1;
    step(); check("pp_reset", q_a, led(8'h01));
    reset_a = 1'b0;
    step(); check("pp_reload", q_a, led(8'h01));
    step(); check("pp_left", q_a, led(8'h02));
    step(); check("pp_left2", q_a, led(8'h04));

    // Mode toggling every cycle: reload each edge, no advance.
    for (int i = 0; i < 4; i++) begin
      mode_a = (i % 2 == 0) ? 2'd0 : 2'd1;
      step(); check("toggle", q_a, led((i % 2 == 0) ? 8'h01 : 8'h80));
    end

    // STEP_DIV=4: advance every four edges.
    reset_b = 1'b0;
    for (int i = 0; i < 8; i++) begin
      step(); check("div4", q_b, led(exp_b[i]));
    end
    step(); check("div4_c1", q_b, led(8'h04));
    step(); check("div4_c2", q_b, led(8'h04));
    // Counter is at 2 here; the mode change reloads and restarts the interval.
    mode_b = 2'd1;
    step(); check("div4_load", q_b, led(8'h80));
    mode_b = 2'd1;
    step(); check("div4_h1", q_b, led(8'h80));
    step(); check("div4_h2", q_b, led(8'h80));
    step(); check("div4_h3", q_b, led(8'h80));
    step(); check("div4_adv", q_b, led(8'h40));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/dich_led.md
# dich_led

LED pattern generator ("dịch LED") driving an 8-LED bank from a 2-bit mode select. It produces four animated patterns: rotate left, rotate right, fill/empty bar and ping-pong. The pattern advances on an internal step tick derived from the system clock. It sits between the board's mode switches and the LED pins, and is simulated directly with a one-cycle step.

## Interface
- STEP_DIV, default 1: clock cycles per pattern step (≥1); 1 means a step on every clock.
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- mode  input  2  pattern select: 0 rotate-left, 1 rotate-right, 2 fill/empty bar, 3 ping-pong.
- q  output  8  LED drive, registered; bit 0 is the rightmost LED.

## Operation
- Internal state:
  - pattern register pat[7:0];
  - mode_q[1:0], the registered active mode;
  - dir/phase bit ph;
  - step counter cnt, 0..STEP_DIV-1, width $clog2(STEP_DIV) with a minimum of 1.
- Step tick: tick = (cnt == STEP_DIV-1). cnt increments each clock and wraps to 0 on tick.
- Reset (synchronous) sets pat=8'h01, mode_q=0, ph=0, cnt=0. Reset has priority over everything else.
- Mode change: on any edge with mode != mode_q, the block does the following and does not advance on that edge:
  - mode_q <= mode;
  - pat <= start(mode);
  - ph <= 0;
  - cnt <= 0.
- Start values: mode 0 → 01; mode 1 → 80; mode 2 → 00; mode 3 → 01.
- Otherwise, on tick, pat advances per mode_q:
  - 0: pat <= {pat[6:0],pat[7]}. Sequence 01,02,04,…,80,01 (period 8).
  - 1: pat <= {pat[0],pat[7:1]}. Sequence 80,40,…,01,80 (period 8).
  - 2, with ph=0 (fill): pat <= {pat[6:0],1'b1}. When pat==FF: shift in 0 instead and set ph=1.
  - 2, with ph=1 (empty): pat <= {pat[6:0],1'b0}. When pat==00: shift in 1 and clear ph.
  - 2, resulting sequence: 00,01,03,…,7F,FF,FE,FC,…,80,00,01 (period 16).
  - 3, with ph=0 (moving left): shift left. The step that produces 80 sets ph=1.
  - 3, with ph=1 (moving right): shift right. The step that produces 01 clears ph.
  - 3, resulting sequence: 01,02,…,80,40,…,02,01,02 (period 14). Each end position is held for one step only.
- Without a tick, pat holds.
- q = pat, subject to the Configuration section.

## Timing
- q is registered; there is no combinational path from mode to q.
- Mode-change latency: q shows start(mode) after the first rising edge on which the new mode is sampled. The first advance occurs STEP_DIV edges later.
- Reset latency: q=01 after the first edge with reset=1. The first advance occurs STEP_DIV edges after the first edge with reset=0.
- Reset together with a mode change: reset wins, giving mode_q=0 and pat=01. On the next edge, a non-zero mode triggers a reload.
- Mode toggling every cycle: each edge reloads start(mode). The pattern never advances.
- All 4 mode codes are legal. There are no illegal states for pat in modes 0, 1 and 3 starting from the start values.

## Configuration
- DICHLED_ACTIVE_LOW_EN:
  - Defined: q = ~pat, for active-low LED boards. The reset value of q becomes FE; in mode 2 the all-off state drives FF.
  - Undefined (default): q = pat, active-high; the reset value of q is 01.
- Internal sequencing is identical in both cases.

## Test plan
- All scenarios below use STEP_DIV=1 unless stated otherwise.
- Reset held 2 cycles with mode=0 → q=01. Release → q=02,04,08,10,20,40,80,01 on consecutive edges.
- mode 0→1 mid-sequence → next edge q=80, then 40,20,…,01,80. Check that no step is skipped or doubled.
- mode=2 for 20 cycles → 00,01,03,07,0F,1F,3F,7F,FF,FE,FC,F8,F0,E0,C0,80,00,01,03,07.
- mode=3 for 16 cycles → 01,02,04,08,10,20,40,80,40,20,10,08,04,02,01,02.
- STEP_DIV=4, mode=0 after reset → q changes exactly every 4 edges. A mode change when cnt=2 reloads immediately and restarts a full 4-edge interval.
- Reset asserted in mode 3 while moving right (q=20) → next edge q=01 and mode_q=0. With mode still 3, the following edge reloads to 01 with ph=0. Repeat with DICHLED_ACTIVE_LOW_EN defined → reset value q=FE.
